// File: rtl/conv_host_pkg.sv
// Shared constants and types for the convolution host.
// Holds the default data/address widths, the layer bank select codes, the
// host FSM state encoding and the layer read-source tag.
package conv_host_pkg;

  localparam int unsigned DW    = 20;
  localparam int unsigned AW    = 12;
  localparam int unsigned L1_AW = 10;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StDrain,
    StDump,
    StDone
  } state_e;

  // Which bank the last layer read came from; RdNone reads back zero.
  typedef enum logic [1:0] {
    RdNone,
    RdL0,
    RdL1
  } rd_sel_e;

endpackage

// File: rtl/conv_host_bank.sv
// Single-clock storage bank: synchronous write, NumRd registered read ports.
// Ports:
//   clk, reset        clock, asynchronous active-low reset (read registers only)
//   we/waddr/wdata    write port
//   re/raddr          per-port read enable and address
//   rdata             per-port registered read data, holds while re is low
// Contents are never cleared by reset; a read and write of the same word in
// one cycle returns the old contents.
module conv_host_bank #(
  parameter int unsigned Dw    = conv_host_pkg::DW,
  parameter int unsigned Depth = 4096,
  parameter int unsigned NumRd = 1,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [Aw-1:0]            waddr,
  input  logic [Dw-1:0]            wdata,
  input  logic [NumRd-1:0]         re,
  input  logic [NumRd-1:0][Aw-1:0] raddr,
  output logic [NumRd-1:0][Dw-1:0] rdata
);

  logic [Dw-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      for (int unsigned i = 0; i < NumRd; i++) begin
        if (re[i]) rdata[i] <= mem[raddr[i]];
      end
    end
  end

endmodule

// File: rtl/conv_host.sv
// Convolution host: image loader, L0/L1 layer memories, run sequencing and
// result dump for an external convolution engine.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   load_valid, load_data         image load stream (auto-incrementing pointer)
//   start                         run request, honoured only with a full image
//   ready / busy                  work-available / engine-running handshake
//   iaddr -> idata                registered image read
//   cwr, caddr_wr, cdata_wr       layer write (bank chosen by csel)
//   crd, caddr_rd -> cdata_rd     layer registered read (bank chosen by csel)
//   csel                          3'b001 L0, 3'b011 L1, other codes no bank
//   dump_valid/addr/data          result stream after a run
//   done                          one-cycle run-complete pulse
// Build option: define CONV_HOST_L0_DUMP_EN to stream all of L0 ahead of L1
// during the dump.
module conv_host #(
  parameter int unsigned DW    = conv_host_pkg::DW,
  parameter int unsigned AW    = conv_host_pkg::AW,
  parameter int unsigned L1_AW = conv_host_pkg::L1_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          done
);
  import conv_host_pkg::*;

  localparam int unsigned ImgDepth = 1 << AW;
  localparam int unsigned L1Depth  = 1 << L1_AW;
`ifdef CONV_HOST_L0_DUMP_EN
  localparam int unsigned DumpBeats = ImgDepth + L1Depth;
  localparam int unsigned L0Rd      = 2;
`else
  localparam int unsigned DumpBeats = L1Depth;
  localparam int unsigned L0Rd      = 1;
`endif
  localparam int unsigned     CntW    = $clog2(DumpBeats + 1);
  localparam logic [CntW-1:0] DumpEnd = CntW'(DumpBeats);

  state_e          state_q, state_d;
  logic [AW:0]     ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  rd_sel_e         rd_sel_q, rd_sel_d;
  logic            dump_valid_q;
  logic [AW-1:0]   dump_addr_q, dump_addr_d;

  logic img_full, img_we, dump_re;
  logic l0_we, l1_we, crd_l0, crd_l1;

  logic [L0Rd-1:0]         l0_re;
  logic [L0Rd-1:0][AW-1:0] l0_raddr;
  logic [L0Rd-1:0][DW-1:0] l0_rdata;
  logic [1:0]              l1_re;
  logic [1:0][L1_AW-1:0]   l1_raddr;
  logic [1:0][DW-1:0]      l1_rdata;

  // Pointer is one bit wider than the image address; the MSB marks "full".
  assign img_full = ptr_q[AW];
  assign img_we   = load_valid && !img_full;

  assign l0_we  = cwr && (csel == CSEL_L0);
  assign l1_we  = cwr && (csel == CSEL_L1) && (caddr_wr[AW-1:L1_AW] == '0);
  assign crd_l0 = crd && (csel == CSEL_L0);
  assign crd_l1 = crd && (csel == CSEL_L1);

  // Beat 0 is fetched during DRAIN (the last engine write has already landed),
  // so every DUMP cycle presents a valid beat.
  assign dump_re = (state_q == StDrain) || ((state_q == StDump) && (cnt_q != DumpEnd));

`ifdef CONV_HOST_L0_DUMP_EN
  logic dump_l1, dump_l1_q;
  assign dump_l1 = (cnt_q >= CntW'(ImgDepth));
  // L0 depth is a multiple of L1 depth, so the low bits give the L1 offset.
  assign dump_addr_d = dump_l1 ? AW'(cnt_q[L1_AW-1:0]) : cnt_q[AW-1:0];
  assign l0_re       = {dump_re && !dump_l1, crd_l0};
  assign l0_raddr    = {cnt_q[AW-1:0], caddr_rd};
  assign l1_re       = {dump_re && dump_l1, crd_l1};
  assign dump_data   = dump_l1_q ? l1_rdata[1] : l0_rdata[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dump_l1_q <= 1'b0;
    else if (dump_re) dump_l1_q <= dump_l1;
  end
`else
  assign dump_addr_d = AW'(cnt_q[L1_AW-1:0]);
  assign l0_re       = crd_l0;
  assign l0_raddr    = caddr_rd;
  assign l1_re       = {dump_re, crd_l1};
  assign dump_data   = l1_rdata[1];
`endif
  assign l1_raddr = {cnt_q[L1_AW-1:0], caddr_rd[L1_AW-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle:  if (start && img_full) state_d = StArm;
      StArm:   if (busy) state_d = StRun;
      StRun:   if (!busy) state_d = StDrain;
      StDrain: begin
        state_d = StDump;
        cnt_d   = CntW'(1);
      end
      StDump: begin
        if (cnt_q == DumpEnd) state_d = StDone;
        else cnt_d = cnt_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StDone) ptr_d = '0;
    else if (img_we) ptr_d = ptr_q + 1'b1;
  end

  always_comb begin
    rd_sel_d = rd_sel_q;
    if (crd) begin
      unique case (csel)
        CSEL_L0: rd_sel_d = RdL0;
        CSEL_L1: rd_sel_d = RdL1;
        default: rd_sel_d = RdNone;
      endcase
    end
  end

  always_comb begin
    cdata_rd = '0;
    unique case (rd_sel_q)
      RdL0:    cdata_rd = l0_rdata[0];
      RdL1:    cdata_rd = l1_rdata[0];
      default: cdata_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cnt_q        <= '0;
      rd_sel_q     <= RdNone;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      rd_sel_q     <= rd_sel_d;
      dump_valid_q <= dump_re;
      if (dump_re) dump_addr_q <= dump_addr_d;
    end
  end

  assign ready      = (state_q == StArm);
  assign done       = (state_q == StDone);
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;

  conv_host_bank #(.Dw(DW), .Depth(ImgDepth), .NumRd(1)) u_img (
    .clk   (clk),
    .reset (reset),
    .we    (img_we),
    .waddr (ptr_q[AW-1:0]),
    .wdata (load_data),
    .re    (1'b1),
    .raddr (iaddr),
    .rdata (idata)
  );

  conv_host_bank #(.Dw(DW), .Depth(ImgDepth), .NumRd(L0Rd)) u_l0 (
    .clk   (clk),
    .reset (reset),
    .we    (l0_we),
    .waddr (caddr_wr),
    .wdata (cdata_wr),
    .re    (l0_re),
    .raddr (l0_raddr),
    .rdata (l0_rdata)
  );

  conv_host_bank #(.Dw(DW), .Depth(L1Depth), .NumRd(2)) u_l1 (
    .clk   (clk),
    .reset (reset),
    .we    (l1_we),
    .waddr (caddr_wr[L1_AW-1:0]),
    .wdata (cdata_wr),
    .re    (l1_re),
    .raddr (l1_raddr),
    .rdata (l1_rdata)
  );

endmodule

// File: tb/tb_conv_host.sv
// Directed-plus-random bench for conv_host with a plain-array memory model.
module tb_conv_host;

`ifdef CONV_HOST_L0_DUMP_EN
  localparam int L0N = 4096;
`else
  localparam int L0N = 0;
`endif
  localparam int Beats = L0N + 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic [19:0] load_data = '0;
  logic        start = 1'b0;
  logic        ready;
  logic        busy = 1'b0;
  logic [11:0] iaddr = '0;
  logic [19:0] idata;
  logic        cwr = 1'b0;
  logic [11:0] caddr_wr = '0;
  logic [19:0] cdata_wr = '0;
  logic        crd = 1'b0;
  logic [11:0] caddr_rd = '0;
  logic [19:0] cdata_rd;
  logic [2:0]  csel = 3'b000;
  logic        dump_valid;
  logic [11:0] dump_addr;
  logic [19:0] dump_data;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [19:0] img_m [4096];
  logic [19:0] l0_m [4096];
  logic [19:0] l1_m [1024];
  logic [19:0] exp_rd;

  conv_host u_dut (
    .clk        (clk),
    .reset      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .start      (start),
    .ready      (ready),
    .busy       (busy),
    .iaddr      (iaddr),
    .idata      (idata),
    .cwr        (cwr),
    .caddr_wr   (caddr_wr),
    .cdata_wr   (cdata_wr),
    .crd        (crd),
    .caddr_rd   (caddr_rd),
    .cdata_rd   (cdata_rd),
    .csel       (csel),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of the layer read: computed before the same-cycle write is applied.
  function automatic logic [19:0] layer_read(input logic [2:0] s, input logic [11:0] a);
    if (s == 3'b001) return l0_m[a];
    if (s == 3'b011) return l1_m[a[9:0]];
    return 20'h0;
  endfunction

  task automatic layer_write(input logic [2:0] s, input logic [11:0] a, input logic [19:0] d);
    if (s == 3'b001) l0_m[a] = d;
    else if (s == 3'b011 && a[11:10] == 2'b00) l1_m[a[9:0]] = d;
  endtask

  initial begin
    logic [11:0] a;
    logic [19:0] ed;
    logic [11:0] ea;
    int bad;

    // Reset state
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_idata", 32'(idata), 32'(0));
    chk("rst_cdata_rd", 32'(cdata_rd), 32'(0));
    chk("rst_dump_valid", 32'(dump_valid), 32'(0));
    chk("rst_dump_addr", 32'(dump_addr), 32'(0));
    chk("rst_dump_data", 32'(dump_data), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst_n = 1'b1;
    step();

    // Start with an empty image is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_empty_ignored", 32'(ready), 32'(0));

    // Load image[i] = i, then one extra word that must be dropped
    for (int i = 0; i < 4096; i++) begin
      load_valid = 1'b1;
      load_data  = 20'(i);
      img_m[i]   = 20'(i);
      step();
    end
    load_data = 20'hFFFFF;
    step();
    load_valid = 1'b0;
    step();
    chk("idata_after_saturate", 32'(idata), 32'(img_m[0]));

    // Registered image read: exactly one cycle of latency
    iaddr = 12'h041;
    #1;
    chk("idata_not_early", 32'(idata), 32'(img_m[0]));
    step();
    chk("idata_041", 32'(idata), 32'h00041);
    for (int n = 0; n < 6; n++) begin
      a = 12'($urandom_range(0, 4095));
      iaddr = a;
      step();
      chk("idata_rand", 32'(idata), 32'(img_m[a]));
    end

    // Start with full image -> ARM; busy never rising holds ARM
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ready_after_start", 32'(ready), 32'(1));
    step();
    step();
    chk("ready_hold_arm", 32'(ready), 32'(1));
    busy = 1'b1;
    #1;
    chk("ready_before_busy_edge", 32'(ready), 32'(1));
    step();
    chk("ready_drop_run", 32'(ready), 32'(0));

    // Engine fills L0 with random data and L1[k] = k
    cwr = 1'b1;
    csel = 3'b001;
    for (int k = 0; k < 4096; k++) begin
      caddr_wr = 12'(k);
      cdata_wr = 20'($urandom());
      layer_write(csel, caddr_wr, cdata_wr);
      step();
    end
    csel = 3'b011;
    for (int k = 0; k < 1024; k++) begin
      caddr_wr = 12'(k);
      cdata_wr = 20'(k);
      layer_write(csel, caddr_wr, cdata_wr);
      step();
    end
    // Out-of-range L1 write must be dropped
    caddr_wr = 12'h400;
    cdata_wr = 20'h5A5A5;
    layer_write(csel, caddr_wr, cdata_wr);
    step();
    cwr = 1'b0;
    crd = 1'b1;
    caddr_rd = 12'h000;
    step();
    chk("l1_0_after_drop", 32'(cdata_rd), 32'(l1_m[0]));

    // L0 write then read, invalid bank reads zero
    crd = 1'b0;
    cwr = 1'b1;
    csel = 3'b001;
    caddr_wr = 12'd5;
    cdata_wr = 20'hABCDE;
    layer_write(csel, caddr_wr, cdata_wr);
    step();
    cwr = 1'b0;
    crd = 1'b1;
    caddr_rd = 12'd5;
    step();
    chk("l0_rd_5", 32'(cdata_rd), 32'hABCDE);
    csel = 3'b010;
    step();
    chk("bad_csel_rd", 32'(cdata_rd), 32'(0));
    crd = 1'b0;
    csel = 3'b001;
    step();
    chk("rd_hold", 32'(cdata_rd), 32'(0));

    // Read-before-write on the same word
    cwr = 1'b1;
    crd = 1'b1;
    csel = 3'b001;
    caddr_wr = 12'd5;
    caddr_rd = 12'd5;
    cdata_wr = 20'h12345;
    exp_rd = layer_read(csel, caddr_rd);
    layer_write(csel, caddr_wr, cdata_wr);
    step();
    chk("rbw_old", 32'(cdata_rd), 32'(exp_rd));

    // Random layer traffic on a small address window to force collisions
    for (int n = 0; n < 200; n++) begin
      int unsigned pick;
      pick = $urandom_range(0, 3);
      csel = (pick == 0) ? 3'b001 : (pick == 1) ? 3'b011 : (pick == 2) ? 3'b010 : 3'b111;
      cwr = 1'($urandom_range(0, 1));
      crd = 1'($urandom_range(0, 1));
      a = 12'($urandom_range(0, 7));
      caddr_wr = ($urandom_range(0, 3) == 0) ? (a | 12'h400) : a;
      caddr_rd = ($urandom_range(0, 1) == 0) ? a : 12'($urandom_range(0, 7));
      cdata_wr = 20'($urandom());
      if (crd) exp_rd = layer_read(csel, caddr_rd);
      if (cwr) layer_write(csel, caddr_wr, cdata_wr);
      step();
      chk("cdata_rd_rand", 32'(cdata_rd), 32'(exp_rd));
    end
    cwr = 1'b0;
    crd = 1'b0;

    // End of run: one drain cycle, then the dump stream
    busy = 1'b0;
    step();
    chk("drain_no_valid", 32'(dump_valid), 32'(0));
    step();
    bad = 0;
    for (int i = 0; i < Beats; i++) begin
      if (i < L0N) begin
        ea = 12'(i);
        ed = l0_m[i];
      end else begin
        ea = 12'(i - L0N);
        ed = l1_m[i - L0N];
      end
      if (!(dump_valid === 1'b1 && dump_addr === ea && dump_data === ed)) bad++;
      step();
    end
    chk("dump_bad_beats", 32'(bad), 32'(0));
    chk("dump_valid_end", 32'(dump_valid), 32'(0));
    chk("done_pulse", 32'(done), 32'(1));
    step();
    chk("done_one_cycle", 32'(done), 32'(0));

    // Pointer cleared at DONE: start without reload is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_after_done_ignored", 32'(ready), 32'(0));

    // Reload with random data, begin a run, then reset in RUN
    for (int i = 0; i < 4096; i++) begin
      load_valid = 1'b1;
      load_data  = 20'($urandom());
      img_m[i]   = load_data;
      step();
    end
    load_valid = 1'b0;
    a = 12'($urandom_range(1, 4095));
    iaddr = a;
    step();
    chk("idata_reload", 32'(idata), 32'(img_m[a]));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ready_second_run", 32'(ready), 32'(1));
    busy = 1'b1;
    crd = 1'b1;
    csel = 3'b011;
    caddr_rd = 12'd3;
    step();
    chk("ready_second_run_drop", 32'(ready), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", 32'(ready), 32'(0));
    chk("midrun_rst_idata", 32'(idata), 32'(0));
    chk("midrun_rst_cdata_rd", 32'(cdata_rd), 32'(0));
    chk("midrun_rst_dump_valid", 32'(dump_valid), 32'(0));
    chk("midrun_rst_done", 32'(done), 32'(0));
    crd = 1'b0;
    busy = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_after_reset_ignored", 32'(ready), 32'(0));

    // Memory contents survive reset
    iaddr = a;
    crd = 1'b1;
    csel = 3'b011;
    caddr_rd = 12'd3;
    step();
    crd = 1'b0;
    chk("img_retained", 32'(idata), 32'(img_m[a]));
    chk("l1_retained", 32'(cdata_rd), 32'(l1_m[3]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_host.md
CONV_HOST -- requirements
Module: conv_host

Interface
REQ-001 Parameter DW, 20, data width of image, L0 and L1 words.
REQ-002 Parameter AW, 12, image/L0 address width (4096 words).
REQ-003 Parameter L1_AW, 10, L1 address width (1024 words).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 load_valid  in  1  image word present on load_data.
REQ-007 load_data  in  DW  image pixel, written at internal load pointer.
REQ-008 start  in  1  one-cycle pulse requesting a convolution run.
REQ-009 ready  out  1  handshake to engine: work available.
REQ-010 busy  in  1  engine running.
REQ-011 iaddr  in  AW  image read address; idata  out  DW  image data.
REQ-012 cwr  in  1, caddr_wr  in  AW, cdata_wr  in  DW  layer write port.
REQ-013 crd  in  1, caddr_rd  in  AW  layer read request; cdata_rd  out  DW  layer read data.
REQ-014 csel  in  3  bank select: 3'b001 L0, 3'b011 L1, other codes select nothing.
REQ-015 dump_valid  out  1, dump_addr  out  AW, dump_data  out  DW  result stream; done  out  1  run complete.

Function
REQ-016 Load pointer SHALL start at 0, write load_data to image[ptr] and increment on each load_valid, saturating at 4096 (further load_valid ignored); image_full when ptr==4096.
REQ-017 FSM states IDLE, ARM, RUN, DRAIN, DUMP, DONE; reset state IDLE.
REQ-018 IDLE->ARM on start with image_full; start without image_full SHALL be ignored.
REQ-019 ARM: ready=1; ARM->RUN on first cycle busy==1; ready SHALL drop in the cycle after busy is sampled high.
REQ-020 RUN->DRAIN when busy==0 after having been 1; busy never rising SHALL hold ARM indefinitely.
REQ-021 DRAIN: one idle cycle so the final cwr lands, then ->DUMP.
REQ-022 idata SHALL be registered: idata(t+1)=image[iaddr(t)], updated every cycle regardless of other signals.
REQ-023 cdata_rd SHALL be registered: on crd=1, cdata_rd(t+1)=bank[csel][caddr_rd(t)]; on crd=0 it holds; invalid csel returns 0.
REQ-024 cwr=1 with csel 3'b001 writes L0[caddr_wr]; with 3'b011 writes L1[caddr_wr[L1_AW-1:0]] only if caddr_wr[AW-1:L1_AW]==0, else dropped; other csel dropped.
REQ-025 Simultaneous cwr and crd to same bank and address SHALL return old data (read-before-write).
REQ-026 DUMP: dump_valid=1 for 1024 consecutive cycles, dump_addr 0..1023 ascending, dump_data=L1[dump_addr], then ->DONE.
REQ-027 DONE: done=1 for one cycle, load pointer cleared to 0, ->IDLE.
REQ-028 busy, cwr or crd outside ARM/RUN/DRAIN SHALL still be serviced per REQ-022..025 (no state effect).

Reset
REQ-029 Reset SHALL force ready=0, idata=0, cdata_rd=0, dump_valid=0, dump_addr=0, dump_data=0, done=0, load pointer=0, state IDLE.
REQ-030 Reset mid-run SHALL abort immediately; memory contents SHALL NOT be cleared.

Configuration
REQ-031 Macro CONV_HOST_L0_DUMP_EN defined: DUMP streams L0 addresses 0..4095 (4096 beats) before L1 0..1023, total 5120 beats; undefined: L1 only per REQ-026.

Structure
REQ-032 Package conv_host_pkg SHALL hold DW/AW/L1_AW constants, CSEL_L0=3'b001, CSEL_L1=3'b011, and the FSM state enum.
REQ-033 Sub-module conv_host_bank (sync write, registered read, parameterised depth) SHALL implement image, L0 and L1 storage.

Verification
REQ-034 Load 4096 words image[i]=i, pulse start -> ready=1 next cycle; assert busy -> ready=0 one cycle later.
REQ-035 iaddr=12'h041 -> idata=20'h00041 exactly one cycle later.
REQ-036 cwr csel=001 addr 5 data 20'hABCDE, then crd csel=001 addr 5 -> cdata_rd=20'hABCDE next cycle; same with csel=010 -> 0.
REQ-037 cwr csel=011 addr 12'h400 -> dropped; L1[0] unchanged in dump.
REQ-038 Busy 1->0 after L1 writes L1[k]=k -> one drain cycle, 1024 dump beats dump_data=k, done pulse; with CONV_HOST_L0_DUMP_EN, 5120 beats.
REQ-039 Reset asserted during RUN -> ready=0, IDLE; subsequent start without reload ignored (pointer 0).
